// File: rtl/ghash_core.sv
// GHASH accumulator: Y = (Y ^ block) * H in GF(2^128), GCM bit order.
// The multiply is digit-serial; each block takes 128/DIGIT cycles.
module ghash_core #(
  parameter int unsigned DIGIT = 8
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic [0:127] iHashkey,
  input  logic         iKeyLoad,
  input  logic         iInit,
  input  logic         iValid,
  output logic         oReady,
  input  logic [0:127] iBlock,
  input  logic         iLast,
  output logic [0:127] oTag,
  output logic         oTagValid,
  output logic         oBusy
);

  localparam int unsigned N       = 128 / DIGIT;
  localparam logic [7:0]  CntLast = 8'(N - 1);
  localparam logic [0:127] RPoly  = {8'hE1, 120'h0};

  typedef enum logic {StIdle, StMul} state_e;

  state_e       r_state, w_state_d;
  logic [0:127] r_h, w_h_d;
  logic [0:127] r_y, w_y_d;
  logic [0:127] r_x, w_x_d;
  logic [0:127] r_z, w_z_d;
  logic [0:127] r_v, w_v_d;
  logic [7:0]   r_cnt, w_cnt_d;
  logic         r_last, w_last_d;
  logic [0:127] r_tag, w_tag_d;
  logic         r_tag_valid, w_tag_valid_d;

  // One digit of the bit-serial GCM multiply; X is pre-shifted so the digit sits at X[0:DIGIT-1].
  logic [0:127] w_z_step, w_v_step;
  always_comb begin
    w_z_step = r_z;
    w_v_step = r_v;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      if (r_x[j]) w_z_step = w_z_step ^ w_v_step;
      w_v_step = {1'b0, w_v_step[0:126]} ^ (RPoly & {128{w_v_step[127]}});
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_h_d         = iKeyLoad ? iHashkey : r_h;
    w_y_d         = r_y;
    w_x_d         = r_x;
    w_z_d         = r_z;
    w_v_d         = r_v;
    w_cnt_d       = r_cnt;
    w_last_d      = r_last;
    w_tag_d       = r_tag;
    w_tag_valid_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (iValid) begin
          w_x_d     = (iInit ? 128'h0 : r_y) ^ iBlock;
          w_z_d     = '0;
          w_v_d     = iKeyLoad ? iHashkey : r_h;
          w_last_d  = iLast;
          w_cnt_d   = '0;
          w_state_d = StMul;
        end else if (iInit) begin
          w_y_d = '0;
        end
      end
      StMul: begin
        if (iInit) begin
          // Abort: drop the in-flight product and start a clean message.
          w_state_d = StIdle;
          w_y_d     = '0;
        end else begin
          w_z_d   = w_z_step;
          w_v_d   = w_v_step;
          w_x_d   = r_x << DIGIT;
          w_cnt_d = r_cnt + 8'd1;
          if (r_cnt == CntLast) begin
            w_y_d     = w_z_step;
            w_state_d = StIdle;
            if (r_last) begin
              w_tag_d       = w_z_step;
              w_tag_valid_d = 1'b1;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state     <= StIdle;
      r_h         <= '0;
      r_y         <= '0;
      r_x         <= '0;
      r_z         <= '0;
      r_v         <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_h         <= w_h_d;
      r_y         <= w_y_d;
      r_x         <= w_x_d;
      r_z         <= w_z_d;
      r_v         <= w_v_d;
      r_cnt       <= w_cnt_d;
      r_last      <= w_last_d;
      r_tag       <= w_tag_d;
      r_tag_valid <= w_tag_valid_d;
    end
  end

  assign oReady    = (r_state == StIdle);
  assign oBusy     = (r_state == StMul);
  assign oTag      = r_tag;
  assign oTagValid = r_tag_valid;

endmodule

// File: tb/tb_ghash_core.sv
// Bench for ghash_core: DIGIT=1, 8 and 32 instances share stimulus and are
// checked against a bit-serial GF(2^128) reference model and GCM test vectors.
module tb_ghash_core;

  localparam logic [0:127] RPoly = {8'hE1, 120'h0};

  logic         clk;
  logic         rst_n;
  logic [0:127] hashkey;
  logic         key_load;
  logic         init;
  logic         valid;
  logic [0:127] block;
  logic         last;

  logic [0:127] tag  [3];
  logic         tvld [3];
  logic         rdy  [3];
  logic         bsy  [3];

  int lat_tab [3] = '{128, 16, 4};

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [0:127] m_h, m_y, m_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ghash_core #(.DIGIT(1)) u_dut1 (
    .iClk(clk), .iRst_n(rst_n), .iHashkey(hashkey), .iKeyLoad(key_load), .iInit(init),
    .iValid(valid), .oReady(rdy[0]), .iBlock(block), .iLast(last), .oTag(tag[0]),
    .oTagValid(tvld[0]), .oBusy(bsy[0])
  );
  ghash_core #(.DIGIT(8)) u_dut8 (
    .iClk(clk), .iRst_n(rst_n), .iHashkey(hashkey), .iKeyLoad(key_load), .iInit(init),
    .iValid(valid), .oReady(rdy[1]), .iBlock(block), .iLast(last), .oTag(tag[1]),
    .oTagValid(tvld[1]), .oBusy(bsy[1])
  );
  ghash_core #(.DIGIT(32)) u_dut32 (
    .iClk(clk), .iRst_n(rst_n), .iHashkey(hashkey), .iKeyLoad(key_load), .iInit(init),
    .iValid(valid), .oReady(rdy[2]), .iBlock(block), .iLast(last), .oTag(tag[2]),
    .oTagValid(tvld[2]), .oBusy(bsy[2])
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // GCM multiply straight from the textbook bit-serial definition.
  function automatic logic [0:127] gf_mul(input logic [0:127] a, input logic [0:127] b);
    logic [0:127] z;
    logic [0:127] v;
    z = '0;
    v = b;
    for (int i = 0; i < 128; i++) begin
      if (a[i]) z = z ^ v;
      v = v[127] ? ((v >> 1) ^ RPoly) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [0:127] k);
    @(negedge clk);
    key_load = 1'b1;
    hashkey  = k;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    m_h = k;
  endtask

  // Accept one block on all DUTs and watch completion, latency and the tag pulse.
  task automatic run_block(input logic [0:127] blk, input logic ini, input logic lst,
                           input logic kl, input logic [0:127] key, input logic hold);
    int done_c  [3];
    int pulses  [3];
    int pulse_c [3];
    logic [0:127] hused;
    for (int k = 0; k < 3; k++) begin
      done_c[k] = 0; pulses[k] = 0; pulse_c[k] = 0;
    end
    @(negedge clk);
    valid = 1'b1; block = blk; init = ini; last = lst; key_load = kl; hashkey = key;
    @(posedge clk);
    #1;
    hused = kl ? key : m_h;
    if (kl) m_h = key;
    m_y = gf_mul((ini ? 128'h0 : m_y) ^ blk, hused);
    if (lst) m_tag = m_y;
    init = 1'b0; last = 1'b0; key_load = 1'b0;
    valid = hold;
    block = rnd128();
    for (int k = 0; k < 3; k++) chk("busy_after_accept", 128'(bsy[k]), 128'd1);
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (tvld[k]) begin pulses[k]++; pulse_c[k] = c; end
        if (done_c[k] == 0 && rdy[k]) done_c[k] = c;
      end
      if (done_c[0] != 0 && c > done_c[0]) break;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("latency_d%0d", k), 128'(done_c[k]), 128'(lat_tab[k]));
      chk($sformatf("pulse_count_d%0d", k), 128'(pulses[k]), lst ? 128'd1 : 128'd0);
      if (lst) chk($sformatf("pulse_cycle_d%0d", k), 128'(pulse_c[k]), 128'(lat_tab[k]));
      chk($sformatf("tag_d%0d", k), tag[k], m_tag);
    end
  endtask

  task automatic abort_block(input logic [0:127] blk);
    int pulses [3];
    for (int k = 0; k < 3; k++) pulses[k] = 0;
    @(negedge clk);
    valid = 1'b1; block = blk; init = 1'b0; last = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; last = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) begin init = 1'b1; valid = 1'b1; block = rnd128(); last = 1'b1; end
      if (c == 3) begin init = 1'b0; valid = 1'b0; last = 1'b0; end
      for (int k = 0; k < 3; k++) if (tvld[k]) pulses[k]++;
    end
    m_y = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_ready_d%0d", k), 128'(rdy[k]), 128'd1);
      chk($sformatf("abort_no_pulse_d%0d", k), 128'(pulses[k]), 128'd0);
      chk($sformatf("abort_tag_kept_d%0d", k), tag[k], m_tag);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 3; k++) begin
      chk({name, "_tag"}, tag[k], 128'h0);
      chk({name, "_tvld"}, 128'(tvld[k]), 128'd0);
      chk({name, "_ready"}, 128'(rdy[k]), 128'd1);
      chk({name, "_busy"}, 128'(bsy[k]), 128'd0);
    end
  endtask

  logic [0:127] tc_h, tc_b1, tc_len, tc_y1, tc_tag2;

  initial begin
    tc_h    = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    tc_b1   = 128'h0388DACE60B6A392F328C2B971B2FE78;
    tc_len  = 128'h00000000000000000000000000000080;
    tc_y1   = 128'h5E2EC746917062882C85B0685353DEB7;
    tc_tag2 = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;
    m_h = '0; m_y = '0; m_tag = '0;
    rst_n = 1'b0; hashkey = '0; key_load = 1'b0; init = 1'b0; valid = 1'b0;
    block = '0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // GCM TC1 and TC2
    load_key(tc_h);
    run_block(128'h0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) chk("tc1_tag", tag[k], 128'h0);
    run_block(tc_b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) chk("tc2_y1", tag[k], tc_y1);
    run_block(tc_b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    run_block(tc_len, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) chk("tc2_tag", tag[k], tc_tag2);

    // Abort clears Y; a following block without iInit then hashes from zero
    abort_block(rnd128());
    run_block(tc_b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) chk("post_abort_y", tag[k], tc_y1);
    run_block(tc_b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    run_block(tc_len, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) chk("post_abort_tc2", tag[k], tc_tag2);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    valid = 1'b1; block = tc_b1; init = 1'b1; last = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; init = 1'b0; last = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_h = '0; m_y = '0; m_tag = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("ready_after_release", 128'(rdy[k]), 128'd1);

    // Key bypass: H register is zero, key loaded in the accept cycle
    run_block(tc_b1, 1'b1, 1'b1, 1'b1, tc_h, 1'b0);
    for (int k = 0; k < 3; k++) chk("key_bypass_y", tag[k], tc_y1);
    run_block(tc_b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    run_block(tc_len, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) chk("fresh_tc2_tag", tag[k], tc_tag2);

    // Randomized messages
    for (int m = 0; m < 6; m++) begin
      int nblk;
      nblk = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) load_key(rnd128());
      for (int b = 0; b < nblk; b++) begin
        run_block(rnd128(), b == 0, b == nblk - 1, $urandom_range(0, 3) == 0, rnd128(),
                  $urandom_range(0, 1) == 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
